// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states and lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        SPLIT2 = 1'b1
    } lsu_state_e;

    // Byte mask of the access size before shifting into lane position.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Data-port bus between the load/store unit (master) and the shared dual-port RAM (slave).
interface lsu_dmem_master_if;

    logic [29:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;

    modport master (output d_addr, d_we, d_be, d_wdata, input d_rdata);
    modport slave  (input d_addr, d_we, d_be, d_wdata, output d_rdata);

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed bytes out of a 64-bit raw window and sign/zero-extends them to 32 bits.
module lsu_load_align (
    input  logic [63:0] raw,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    import lsu_pkg::*;

    logic [31:0] win;

    always_comb begin
        win = 32'(raw >> {off, 3'b000});
        case (funct3)
            F3_B:    data = {{24{win[7]}}, win[7:0]};
            F3_H:    data = {{16{win[15]}}, win[15:0]};
            F3_BU:   data = {24'h0, win[7:0]};
            F3_HU:   data = {16'h0, win[15:0]};
            default: data = win;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// MEM-stage load/store unit driving the RAM data port; splits word-crossing accesses in two.
// LSU_MISALIGN_TRAP_EN: trap any non-naturally-aligned access instead of splitting it.
//
// state  | meaning
// IDLE   | accepting requests; issues the (low) word access combinationally
// SPLIT2 | busy; issues the upper word of a crossing access
module lsu_dmem_master #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              lsu_err,
    lsu_dmem_master_if.master dmem
);
    import lsu_pkg::*;

    // The RAM decodes only the low ADDR_WIDTH bits; the full 30-bit word address is always driven.
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_addr_width_chk
        $error("lsu_dmem_master: ADDR_WIDTH must lie in 1..30");
    end

    lsu_state_e  state_q, state_d;
    logic [29:0] hi_addr_q;
    logic [3:0]  hi_be_q;
    logic [31:0] hi_wdata_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [31:0] hold_q;
    logic        rsp_pend_q, rsp_split_q, err_q;

    logic [1:0]  off;
    logic [7:0]  lane8;
    logic [31:0] repl;
    logic [63:0] data64;
    logic        legal, crossing, accept, go, split, err_d;
    logic [29:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;

    always_comb begin
        off      = req_addr[1:0];
        lane8    = {4'b0000, size_mask(req_funct3)} << off;
        case (req_funct3[1:0])
            2'b00:   repl = {4{req_wdata[7:0]}};
            2'b01:   repl = {2{req_wdata[15:0]}};
            default: repl = req_wdata;
        endcase
        data64   = {32'h0, repl} << {off, 3'b000};
        legal    = funct3_legal(req_we, req_funct3);
        crossing = |lane8[7:4];
        accept   = req_valid && (state_q == IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
        // Every crossing access is also misaligned, so split can never rise here.
        go       = accept && legal &&
                   !((req_funct3[1:0] == 2'b01 && off[0]) || (req_funct3[1:0] == 2'b10 && off != 2'b00));
        err_d    = accept && !go;
`else
        go       = accept && legal;
        err_d    = accept && !legal;
`endif
        split    = go && crossing;

        state_d  = (state_q == IDLE && split) ? SPLIT2 : IDLE;

        d_addr   = req_addr[31:2];
        d_we     = 1'b0;
        d_be     = 4'b0000;
        d_wdata  = 32'h0;
        if (state_q == SPLIT2) begin
            d_addr  = hi_addr_q;
            d_we    = we_q;
            d_be    = hi_be_q;
            d_wdata = hi_wdata_q;
        end else if (go) begin
            d_we    = req_we;
            d_be    = lane8[3:0];
            d_wdata = data64[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hi_addr_q   <= '0;
            hi_be_q     <= '0;
            hi_wdata_q  <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            hold_q      <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_split_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            rsp_pend_q  <= 1'b0;
            rsp_split_q <= 1'b0;
            if (go) begin
                off_q      <= off;
                f3_q       <= req_funct3;
                we_q       <= req_we;
                rsp_pend_q <= !req_we && !split;
            end
            if (split) begin
                hi_addr_q  <= req_addr[31:2] + 30'd1;
                hi_be_q    <= lane8[7:4];
                hi_wdata_q <= data64[63:32];
            end
            // Low word of a split load arrives while the upper word is being addressed.
            if (state_q == SPLIT2 && !we_q) begin
                hold_q      <= dmem.d_rdata;
                rsp_pend_q  <= 1'b1;
                rsp_split_q <= 1'b1;
            end
        end
    end

    logic [63:0] raw;
    logic [31:0] ext;

    assign raw = rsp_split_q ? {dmem.d_rdata, hold_q} : {32'h0, dmem.d_rdata};

    lsu_load_align u_align (
        .raw    (raw),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (ext)
    );

    assign busy         = (state_q == SPLIT2);
    assign rsp_valid    = rsp_pend_q;
    assign rsp_rdata    = rsp_pend_q ? ext : 32'h0;
    assign lsu_err      = err_q;
    assign dmem.d_addr  = d_addr;
    assign dmem.d_we    = d_we;
    assign dmem.d_be    = d_be;
    assign dmem.d_wdata = d_wdata;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: RAM slave model plus a byte-level reference memory and random requests.
module tb_lsu_dmem_master;
    import lsu_pkg::*;

    localparam int AW = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, rsp_valid, lsu_err;
    logic [31:0] rsp_rdata;

    lsu_dmem_master_if dmem ();

    lsu_dmem_master #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .lsu_err    (lsu_err),
        .dmem       (dmem)
    );

    always #5 clk = ~clk;

    // RAM slave: registered read, read data held on write cycles.
    logic [31:0] mem [0:(1<<AW)-1] = '{default: '0};
    logic [31:0] ram_rdata = 32'h0;
    always @(posedge clk) begin
        if (dmem.d_we) begin
            for (int l = 0; l < 4; l++)
                if (dmem.d_be[l]) mem[dmem.d_addr[AW-1:0]][8*l +: 8] <= dmem.d_wdata[8*l +: 8];
        end else begin
            ram_rdata <= mem[dmem.d_addr[AW-1:0]];
        end
    end
    assign dmem.d_rdata = ram_rdata;

    // Reference memory as bytes, keyed by the byte address bits the RAM decodes.
    logic [7:0] refm [0:(1<<(AW+2))-1] = '{default: '0};
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit f3_ok(input bit we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return refm[a[AW+1:0]];
    endfunction

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got);
        int          size, off, k;
        bit          access, split, rsp1;
        logic [3:0]  be_lo, be_hi;
        logic [31:0] wd_lo, wd_hi, exp_ld, a;
        logic [29:0] w_lo, w_hi;
        got = '0; be_lo = '0; be_hi = '0; wd_lo = '0; wd_hi = '0; exp_ld = '0;
        size   = 1 << f3[1:0];
        off    = int'(addr[1:0]);
        access = f3_ok(we, f3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (access && (off % size) != 0) access = 0;
`endif
        split = access && (off + size > 4);
        rsp1  = access && !we && !split;
        w_lo  = addr[31:2];
        w_hi  = w_lo + 30'd1;
        if (access) begin
            for (int i = 0; i < size; i++)
                if (off + i < 4) be_lo[off+i] = 1'b1;
                else be_hi[off+i-4] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                k = j - off;
                if (k >= 0) wd_lo[8*j +: 8] = wd[8*(k % size) +: 8];
                k = j + 4 - off;
                if (k < 4) wd_hi[8*j +: 8] = wd[8*(k % size) +: 8];
            end
            for (int i = size - 1; i >= 0; i--) exp_ld = {exp_ld[23:0], ref_byte(addr + 32'(i))};
            if (size == 1 && !f3[2]) exp_ld = {{24{exp_ld[7]}}, exp_ld[7:0]};
            if (size == 2 && !f3[2]) exp_ld = {{16{exp_ld[15]}}, exp_ld[15:0]};
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        chk("n_addr",  32'(dmem.d_addr), 32'(w_lo));
        chk("n_we",    32'(dmem.d_we),   32'(access && we));
        chk("n_be",    32'(dmem.d_be),   32'(be_lo));
        chk("n_wdata", dmem.d_wdata,     wd_lo);
        chk("n_busy",  32'(busy),        32'h0);
        @(posedge clk); @(negedge clk);
        chk("n1_err",       32'(lsu_err),   32'(!access));
        chk("n1_busy",      32'(busy),      32'(split));
        chk("n1_rsp_valid", 32'(rsp_valid), 32'(rsp1));
        chk("n1_rdata",     rsp_rdata,      rsp1 ? exp_ld : 32'h0);
        if (rsp1) got = rsp_rdata;
        if (split) begin
            // Pipeline keeps presenting something while busy; it must be ignored.
            req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            #1;
            chk("n2_addr",  32'(dmem.d_addr), 32'(w_hi));
            chk("n2_we",    32'(dmem.d_we),   32'(we));
            chk("n2_be",    32'(dmem.d_be),   32'(be_hi));
            chk("n2_wdata", dmem.d_wdata,     wd_hi);
            @(posedge clk); @(negedge clk);
            chk("n2_busy",      32'(busy),      32'h0);
            chk("n2_err",       32'(lsu_err),   32'h0);
            chk("n2_rsp_valid", 32'(rsp_valid), 32'(!we));
            chk("n2_rdata",     rsp_rdata,      we ? 32'h0 : exp_ld);
            if (!we) got = rsp_rdata;
        end
        if (access && we)
            for (int i = 0; i < size; i++) begin
                a = addr + 32'(i);
                refm[a[AW+1:0]] = wd[8*i +: 8];
            end
        req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        #1;
        chk("idle_addr",  32'(dmem.d_addr), 32'(req_addr[31:2]));
        chk("idle_we",    32'(dmem.d_we),   32'h0);
        chk("idle_be",    32'(dmem.d_be),   32'h0);
        chk("idle_wdata", dmem.d_wdata,     32'h0);
        @(posedge clk); @(negedge clk);
        chk("idle_rsp", 32'(rsp_valid), 32'h0);
        chk("idle_err", 32'(lsu_err),   32'h0);
    endtask

    initial begin
        logic [31:0] got;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_rsp",   32'(rsp_valid), 32'h0);
        chk("rst_err",   32'(lsu_err),   32'h0);
        chk("rst_rdata", rsp_rdata,      32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, F3_W, 32'h400, 32'h8899AABB, got);
        do_req(1'b0, F3_B, 32'h401, 32'h0, got);
        chk("plan_lb", got, 32'hFFFFFFAA);
        do_req(1'b0, F3_BU, 32'h401, 32'h0, got);
        chk("plan_lbu", got, 32'h000000AA);
        do_req(1'b1, F3_H, 32'h402, 32'h00001234, got);
        do_req(1'b0, F3_W, 32'h400, 32'h0, got);
        chk("plan_sh_word", got, 32'h1234AABB);

        do_req(1'b1, F3_W, 32'h400, 32'h44332211, got);
        do_req(1'b1, F3_W, 32'h404, 32'h88776655, got);
        do_req(1'b0, F3_W, 32'h402, 32'h0, got);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("plan_lw_split", got, 32'h66554433);
`endif
        do_req(1'b1, F3_W, 32'hFFFF_FFFC, 32'hA1B2C3D4, got);
        do_req(1'b1, F3_W, 32'h0000_0000, 32'h5566E7F8, got);
        do_req(1'b0, F3_H, 32'hFFFF_FFFF, 32'h0, got);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("plan_lh_wrap", got, 32'hFFFFF8A1);
`endif
        do_req(1'b0, 3'b011, 32'h400, 32'h0, got);
        do_req(1'b1, 3'b011, 32'h400, 32'hFFFFFFFF, got);
        do_req(1'b1, F3_BU, 32'h404, 32'hFFFFFFFF, got);
        do_req(1'b0, 3'b111, 32'h404, 32'h0, got);

`ifndef LSU_MISALIGN_TRAP_EN
        // Reset while the upper half of a split store is on the bus.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h403; req_wdata = 32'hDEADBEEF;
        #1;
        chk("sw_n_be",   32'(dmem.d_be),          32'h8);
        chk("sw_n_wd",   32'(dmem.d_wdata[31:24]), 32'hEF);
        @(posedge clk); @(negedge clk);
        chk("sw_n1_busy", 32'(busy),              32'h1);
        chk("sw_n1_addr", 32'(dmem.d_addr),       32'h101);
        chk("sw_n1_be",   32'(dmem.d_be),         32'h7);
        chk("sw_n1_wd",   32'(dmem.d_wdata[23:0]), 32'hDEADBE);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy),      32'h0);
        chk("mid_rst_rsp",  32'(rsp_valid), 32'h0);
        chk("mid_rst_err",  32'(lsu_err),   32'h0);
        chk("mid_rst_we",   32'(dmem.d_we), 32'h0);
        refm[16'h403] = 8'hEF;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, F3_W, 32'h400, 32'h0, got);
        chk("rst_lo_word", got, 32'hEF332211);
        do_req(1'b0, F3_W, 32'h404, 32'h0, got);
        chk("rst_hi_word", got, 32'h88776655);
`endif

        for (int i = 0; i < 24; i++) do_req(1'b1, F3_W, 32'h400 + 32'(4 * i), $urandom, got);
        idle_cycle();

        for (int t = 0; t < 300; t++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0:       f3 = F3_B;
                    1:       f3 = F3_H;
                    2:       f3 = F3_W;
                    3:       f3 = F3_BU;
                    default: f3 = F3_HU;
                endcase
            end
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'h400 + 32'($urandom_range(0, 63));
            do_req(we, f3, a, $urandom, got);
            if ($urandom_range(0, 5) == 0) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- MEM-stage load/store unit of the RV32I pipeline; the initiator for the data port of the shared dual-port RAM.
- Turns pipeline load/store requests (byte address, funct3, store data) into word address, byte enables and lane-aligned write data.
- Extracts and sign/zero-extends load data from the RAM's registered 1-cycle read port.
- Splits word-crossing accesses into two RAM accesses, stalling the pipeline for the second one.

Parameters:
- ADDR_WIDTH, 14, RAM word-address bits actually decoded; upper d_addr bits driven but ignored by RAM.

Ports:
- clk  input  1  system clock, all flops on posedge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present this cycle
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I width/sign code
- req_addr  input  32  byte address
- req_wdata  input  32  store data (rs2)
- busy  output  1  unit cannot accept a request; pipeline holds the MEM stage
- rsp_valid  output  1  load data valid this cycle
- rsp_rdata  output  32  extended load result; 0 when rsp_valid=0
- lsu_err  output  1  one-cycle error pulse
- d_addr  output  30  RAM word address [31:2]
- d_we  output  1  RAM write enable
- d_be  output  4  RAM byte enables
- d_wdata  output  32  RAM write data, lane-aligned
- d_rdata  input  32  RAM read data, valid 1 cycle after the address; not updated on write cycles

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n). Reset clears all flops: state=IDLE, busy=0, rsp_valid=0, lsu_err=0, hold register=0.
- Reset during SPLIT2 abandons the access. The first half of a split store stays written.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- Illegal funct3 (or store with funct3 ≥ 011): no RAM access, no rsp_valid; lsu_err=1 in cycle N+1.
- Let off=req_addr[1:0] and size mask m = 0001/0011/1111 for B/H/W.
- 8-bit lane mask M = {4'b0,m} << off. 64-bit data D = {32'b0, replicated data} << 8*off. Byte is replicated x4, halfword x2.
- Crossing access when M[7:4]≠0: SH at off=3, or SW at off≠0. SH at off=1 fits in one word (d_be=0110) and is not crossing.
- FSM IDLE (non-crossing, request accepted in cycle N):
  - Combinational outputs in cycle N: d_addr=req_addr[31:2], d_be=M[3:0], d_wdata=D[31:0], d_we=req_we.
  - A load registers off and funct3; rsp_valid=1 in N+1 with rsp_rdata extracted from d_rdata.
  - Back-to-back loads are allowed every cycle. A store gives no response.
- FSM IDLE (crossing): cycle N issues the low word exactly as above. Registers addr+4, M[7:4], D[63:32], off, funct3 and req_we; moves to SPLIT2.
- FSM SPLIT2 (cycle N+1):
  - busy=1.
  - Drives d_addr=word+1; 30-bit wrap, so 3FFF_FFFF wraps to 0.
  - Drives d_be=M[7:4], d_wdata=D[63:32], d_we from the registered req_we.
  - A load captures d_rdata (low word) into the hold register.
  - Returns to IDLE. A load asserts rsp_valid in N+2 with data = ({d_rdata, hold} >> 8*off) extended.
- req_valid while busy=1 is ignored; the pipeline holds the request.
- When idle with no request: d_we=0, d_be=0, d_wdata=0, d_addr=req_addr[31:2].
- Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: no split and SPLIT2 unreachable. Any non-natural alignment (LH/LHU/SH at odd off; LW/SW at off≠0) causes no RAM access and no response; lsu_err=1 in N+1.
- Undefined: splitting as in Behaviour; lsu_err only for illegal funct3.

Decomposition:
- lsu_pkg: funct3 localparams/enum (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, SPLIT2}, size-mask function.
- Sub-module lsu_load_align: combinational; inputs 64-bit raw, off, funct3; output 32-bit extended data.

Test Plan:
- RAM word 0x100=0x8899AABB; LB addr 0x401 -> rsp_valid in N+1, rsp_rdata=0xFFFFFFAA; LBU same -> 0x000000AA; busy stays 0.
- SH 0x1234 at addr 0x402 -> d_be=1100, d_wdata=0x12341234, d_we=1 for one cycle; word becomes 0x1234AABB.
- SW 0xDEADBEEF at 0x403 (macro off) -> N: addr 0x100, be 1000, wdata[31:24]=EF; N+1: busy=1, addr 0x101, be 0111, wdata[23:0]=DEADBE.
- Words 0x100=0x44332211, 0x101=0x88776655; LW 0x402 -> busy in N+1, rsp_valid only in N+2, rsp_rdata=0x66554433. With LSU_MISALIGN_TRAP_EN: lsu_err N+1, no rsp_valid, d_we=0.
- LH at 0xFFFF_FFFF -> second access d_addr=0; funct3=011 load -> lsu_err=1 N+1, no rsp.
- Assert rst_n=0 during SPLIT2 -> busy, rsp_valid, lsu_err 0 immediately; next request handled normally.
